// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Groups every signal between the two masters, the arbiter and the
// peripheral Bus.
//   m0_* / m1_*  : request, command, grant, done and read data per master
//   bus_*        : single-cycle command to the Bus and its combinational
//                  read data
// Modports:
//   slave  - the arbiter side (receives master commands, drives the Bus)
//   master - the environment side (drives master commands, models the Bus)
//
// Handshake: a master raises mX_req with we/re/wob/addr/wdata stable and
// holds them until mX_done. The arbiter samples the command on the cycle it
// grants the master. mX_gnt is high for the ACCESS and RESP cycles.
// mX_done pulses for exactly the RESP cycle, and mX_rdata is valid in that
// cycle. A req still high in the following cycle counts as a new request.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic        m0_re;
    logic        m0_wob;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_done;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic        m1_re;
    logic        m1_wob;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_done;
    logic [31:0] m1_rdata;

    logic        bus_we;
    logic        bus_re;
    logic        bus_wob;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport slave (
        input  m0_req, m0_we, m0_re, m0_wob, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_re, m1_wob, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output bus_we, bus_re, bus_wob, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output m0_req, m0_we, m0_re, m0_wob, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_re, m1_wob, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  bus_we, bus_re, bus_wob, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Two-master arbiter in front of the peripheral Bus. Master 0 is the CPU
// MEM stage. Master 1 is a secondary requester. Each transaction takes three
// cycles (IDLE -> ACCESS -> RESP), and the Bus sees one single-cycle access.
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   bus        bus_arbiter_if.slave (master commands and Bus drive)
//   dbg_state  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// Parameters:
//   FIXED_PRIO 0 = round-robin on ties, 1 = master 0 always wins ties
module bus_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = m0, 1 = m1
    logic        owner_q, owner_d;             // master owning the current transaction
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_re_q, cmd_re_d;
    logic        cmd_wob_q, cmd_wob_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        win;
    logic [31:0] rd_val;
    logic        in_access;
    logic        owned;
    logic        in_resp;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cmd_we_d     = cmd_we_q;
        cmd_re_d     = cmd_re_q;
        cmd_wob_d    = cmd_wob_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win          = 1'b0;
        rd_val       = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    if (bus.m0_req && bus.m1_req) begin
                        // Tie: fixed priority favours m0. Round-robin
                        // favours whoever was not granted last.
                        win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
                    end else begin
                        win = bus.m1_req;
                    end
                    state_d      = ACCESS;
                    owner_d      = win;
                    last_grant_d = win;
                    // Latch the command so the master is free to change
                    // its inputs once granted.
                    cmd_we_d     = win ? bus.m1_we    : bus.m0_we;
                    cmd_re_d     = win ? bus.m1_re    : bus.m0_re;
                    cmd_wob_d    = win ? bus.m1_wob   : bus.m0_wob;
                    cmd_addr_d   = win ? bus.m1_addr  : bus.m0_addr;
                    cmd_wdata_d  = win ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // A write (including we+re) or a null access leaves 0 behind.
                rd_val  = (cmd_re_q && !cmd_we_q) ? bus.bus_rdata : 32'd0;
                if (owner_q) begin
                    rdata1_d = rd_val;
                end else begin
                    rdata0_d = rd_val;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_re_q     <= 1'b0;
            cmd_wob_q    <= 1'b0;
            cmd_addr_q   <= 32'd0;
            cmd_wdata_q  <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_re_q     <= cmd_re_d;
            cmd_wob_q    <= cmd_wob_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign owned     = in_access || in_resp;

    // Enables are gated by reset, so a write in flight during a reset cycle
    // never reaches a peripheral.
    assign bus.bus_we    = in_access && cmd_we_q && !reset;
    assign bus.bus_re    = in_access && cmd_re_q && !cmd_we_q && !reset;
    assign bus.bus_wob   = in_access && cmd_wob_q;
    assign bus.bus_addr  = in_access ? cmd_addr_q  : 32'd0;
    assign bus.bus_wdata = in_access ? cmd_wdata_q : 32'd0;

    assign bus.m0_gnt   = owned && !owner_q;
    assign bus.m1_gnt   = owned && owner_q;
    // A reset landing on RESP aborts the transaction, so it produces no done.
    assign bus.m0_done  = in_resp && !owner_q && !reset;
    assign bus.m1_done  = in_resp && owner_q && !reset;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Drives two arbiters from one shared clock and reset. Instance 0 uses
// round-robin arbitration and instance 1 uses fixed priority.
// Directed transactions push their hand-computed Bus command and done/rdata
// into per-instance queues. A negedge monitor pops and compares them
// whenever a grant starts (ACCESS) or a done pulse appears.
module tb_bus_arbiter;

    logic clk;
    logic reset;

    logic        m_req   [2][2];
    logic        m_we    [2][2];
    logic        m_re    [2][2];
    logic        m_wob   [2][2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic        gnt_w   [2][2];
    logic        done_w  [2][2];
    logic [31:0] rdata_w [2][2];
    logic        bwe_w   [2];
    logic        bre_w   [2];
    logic        bwob_w  [2];
    logic [31:0] baddr_w [2];
    logic [31:0] bwdata_w[2];
    logic [31:0] brdata  [2];
    logic [1:0]  state_w [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        bus_arbiter_if ifc();

        assign ifc.m0_req   = m_req[g][0];
        assign ifc.m0_we    = m_we[g][0];
        assign ifc.m0_re    = m_re[g][0];
        assign ifc.m0_wob   = m_wob[g][0];
        assign ifc.m0_addr  = m_addr[g][0];
        assign ifc.m0_wdata = m_wdata[g][0];
        assign ifc.m1_req   = m_req[g][1];
        assign ifc.m1_we    = m_we[g][1];
        assign ifc.m1_re    = m_re[g][1];
        assign ifc.m1_wob   = m_wob[g][1];
        assign ifc.m1_addr  = m_addr[g][1];
        assign ifc.m1_wdata = m_wdata[g][1];
        assign ifc.bus_rdata = brdata[g];

        assign gnt_w[g][0]   = ifc.m0_gnt;
        assign gnt_w[g][1]   = ifc.m1_gnt;
        assign done_w[g][0]  = ifc.m0_done;
        assign done_w[g][1]  = ifc.m1_done;
        assign rdata_w[g][0] = ifc.m0_rdata;
        assign rdata_w[g][1] = ifc.m1_rdata;
        assign bwe_w[g]    = ifc.bus_we;
        assign bre_w[g]    = ifc.bus_re;
        assign bwob_w[g]   = ifc.bus_wob;
        assign baddr_w[g]  = ifc.bus_addr;
        assign bwdata_w[g] = ifc.bus_wdata;

        bus_arbiter #(.FIXED_PRIO(g)) dut (
            .clk       (clk),
            .reset     (reset),
            .bus       (ifc.slave),
            .dbg_state (state_w[g])
        );

        // Scoreboard queues: {owner, we, re, wob, addr, wdata} and {owner, rdata}
        logic [67:0] exp_bus_q[$];
        logic [32:0] exp_done_q[$];

        int          cyc = 0;
        int          acc_cyc = 0;
        logic [1:0]  prev_g = 2'b00;
        logic [1:0]  gv;
        logic [1:0]  dv;
        logic [67:0] eb;
        logic [32:0] ed;
        logic [31:0] rd;

        always @(negedge clk) begin
            cyc++;
            if (reset) begin
                prev_g = 2'b00;
            end else begin
                gv = {gnt_w[g][1], gnt_w[g][0]};
                dv = {done_w[g][1], done_w[g][0]};
                if (gv != 2'b00 && prev_g == 2'b00) begin
                    acc_cyc = cyc;
                    if (exp_bus_q.size() == 0) begin
                        chk($sformatf("u%0d_unexpected_grant", g), {66'd0, gv}, 68'd0);
                    end else begin
                        eb = exp_bus_q.pop_front();
                        chk($sformatf("u%0d_bus_access", g),
                            {gv[1], bwe_w[g], bre_w[g], bwob_w[g], baddr_w[g], bwdata_w[g]}, eb);
                    end
                end else begin
                    chk($sformatf("u%0d_bus_quiet", g),
                        {1'b0, bwe_w[g], bre_w[g], bwob_w[g], baddr_w[g], bwdata_w[g]}, 68'd0);
                end
                if (dv != 2'b00) begin
                    if (exp_done_q.size() == 0) begin
                        chk($sformatf("u%0d_unexpected_done", g), {66'd0, dv}, 68'd0);
                    end else begin
                        ed = exp_done_q.pop_front();
                        rd = ed[32] ? rdata_w[g][1] : rdata_w[g][0];
                        chk($sformatf("u%0d_done_timing", g), 68'(cyc - acc_cyc), 68'd1);
                        chk($sformatf("u%0d_done", g), {32'd0, dv, gv, rd},
                            {32'd0, (ed[32] ? 2'b10 : 2'b01), (ed[32] ? 2'b10 : 2'b01), ed[31:0]});
                    end
                end
                prev_g = gv;
            end
        end
    end

    task automatic set_cmd(input int d, input int m, input logic req, input logic we,
                           input logic re, input logic wob, input logic [31:0] addr,
                           input logic [31:0] wdata);
        m_req[d][m]   = req;
        m_we[d][m]    = we;
        m_re[d][m]    = re;
        m_wob[d][m]   = wob;
        m_addr[d][m]  = addr;
        m_wdata[d][m] = wdata;
    endtask

    task automatic push_txn(input int d, input logic mm, input logic bwe, input logic bre,
                            input logic bwob, input logic [31:0] baddr,
                            input logic [31:0] bwdata, input logic [31:0] rdata);
        if (d == 0) begin
            u[0].exp_bus_q.push_back({mm, bwe, bre, bwob, baddr, bwdata});
            u[0].exp_done_q.push_back({mm, rdata});
        end else begin
            u[1].exp_bus_q.push_back({mm, bwe, bre, bwob, baddr, bwdata});
            u[1].exp_done_q.push_back({mm, rdata});
        end
    endtask

    // Waits for n done pulses on instance d, then returns just after the next edge.
    task automatic wait_dones(input int d, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 60 && cnt < n; i++) begin
            @(negedge clk);
            if (done_w[d][0] || done_w[d][1]) cnt++;
        end
        if (cnt < n) chk($sformatf("u%0d_done_timeout", d), 68'(cnt), 68'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int d, input int m, input logic we, input logic re,
                          input logic wob, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic bwe, input logic bre, input logic [31:0] rdata);
        push_txn(d, m[0], bwe, bre, wob, addr, wdata, rdata);
        set_cmd(d, m, 1'b1, we, re, wob, addr, wdata);
        wait_dones(d, 1);
        m_req[d][m] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            brdata[d] = 32'd0;
            for (int m = 0; m < 2; m++) set_cmd(d, m, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state of both instances
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d_reset_outputs", d),
                {gnt_w[d][0], gnt_w[d][1], done_w[d][0], done_w[d][1], bwe_w[d], bre_w[d],
                 bwob_w[d], baddr_w[d][28:0], bwdata_w[d]}, 68'd0);
            chk($sformatf("u%0d_reset_rdata", d), {4'd0, rdata_w[d][0], rdata_w[d][1]}, 68'd0);
            chk($sformatf("u%0d_reset_state", d), 68'(state_w[d]), 68'd0);
        end
        @(posedge clk);
        #1;

        // Round-robin, both masters requesting continuously: m0, m1, m0, m1
        brdata[0] = 32'hCAFE_0001;
        push_txn(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_0001);
        push_txn(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h77, 32'h0);
        push_txn(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_0001);
        push_txn(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h77, 32'h0);
        set_cmd(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_cmd(0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h77);
        wait_dones(0, 4);
        m_req[0][0] = 1'b0;
        m_req[0][1] = 1'b0;

        // m1 read, then m1 byte write to the 7-seg register clears m1_rdata
        brdata[0] = 32'h1111_2222;
        single(0, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
        single(0, 1, 1'b1, 1'b0, 1'b1, 32'h4000_0010, 32'h0000_0F3F, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("u0_m0_rdata_kept", 68'(rdata_w[0][0]), 68'hCAFE_0001);
        @(posedge clk);
        #1;

        // we+re is a write only; read then null access clears rdata again
        single(0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0);
        brdata[0] = 32'h0000_3333;
        single(0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 1'b1, 32'h0000_3333);
        single(0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h99, 1'b0, 1'b0, 32'h0);

        // Fixed priority instance: m0 read of the system counter
        brdata[1] = 32'h0000_1234;
        single(1, 0, 1'b0, 1'b1, 1'b0, 32'h4000_0014, 32'h0, 1'b0, 1'b1, 32'h0000_1234);

        // Fixed priority, both requesting: m0 three times, m1 once m0 drops
        brdata[1] = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++)
            push_txn(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_BEEF);
        set_cmd(1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        set_cmd(1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        wait_dones(1, 3);
        m_req[1][0] = 1'b0;
        push_txn(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_BEEF);
        wait_dones(1, 1);
        m_req[1][1] = 1'b0;

        // Reset during an ACCESS write: enable suppressed, no done, rdata cleared
        set_cmd(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0010, 32'h55);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_req[0][0] = 1'b0;
        @(negedge clk);
        chk("u0_reset_in_access", {65'd0, state_w[0], gnt_w[0][0]}, {65'd0, 2'd1, 1'b1});
        chk("u0_reset_write_suppressed", {66'd0, bwe_w[0], bre_w[0]}, 68'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("u0_post_reset_state", 68'(state_w[0]), 68'd0);
        chk("u0_post_reset_no_done",
            {64'd0, done_w[0][0], done_w[0][1], gnt_w[0][0], gnt_w[0][1]}, 68'd0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("u%0d_post_reset_rdata", d), {4'd0, rdata_w[d][0], rdata_w[d][1]}, 68'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained",
            68'(u[0].exp_bus_q.size() + u[0].exp_done_q.size()
                + u[1].exp_bus_q.size() + u[1].exp_done_q.size()), 68'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
